// File: rtl/hls_run_sequencer.sv
// -----------------------------------------------------------------------------
// hls_run_sequencer
//
// Run controller placed directly upstream of a Bambu-generated HLS top (main).
// For every accepted request it:
//   1. holds the HLS core in reset for RESET_HOLD cycles,
//   2. pulses start_port for one cycle,
//   3. counts cycles until done_port (optionally bounded by a watchdog),
//   4. returns a {status, cycles} record over a valid/ready handshake.
//
// Optional feature macro: HLS_RUN_TIMEOUT_EN
//   defined   -> watchdog active; WAIT ends after TIMEOUT_CYCLES without done
//                and reports status 2'b01. The core is reset for one cycle on
//                entry to REPORT after a timeout.
//   undefined -> no watchdog; status is always 2'b00 (TIMEOUT_CYCLES unused).
//
// Parameters
//   CNT_W          width of the cycle counter and res_cycles
//   RESET_HOLD     cycles dut_reset_n is held low before start (min 1)
//   TIMEOUT_CYCLES watchdog limit in cycles
//
// Ports
//   clock          single clock, rising edge
//   reset          asynchronous, active-high
//   req_valid      run request
//   req_ready      high in IDLE only
//   dut_reset_n    reset to the HLS core (active-low)
//   dut_start_port start_port of the HLS core, one-cycle pulse
//   dut_done_port  done_port from the HLS core
//   res_valid      result record valid
//   res_ready      result consumer ready
//   res_status     2'b00 done, 2'b01 timeout
//   res_cycles     cycle count of the run (saturating)
//   busy           high whenever a run is in progress (RST..REPORT)
//   dbg_state      current FSM state for debug and checkers
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; valid never depends combinationally on ready, and every output here
// is a register.
// -----------------------------------------------------------------------------
module hls_run_sequencer #(
  parameter int CNT_W          = 32,
  parameter int RESET_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             dut_reset_n,
  output logic             dut_start_port,
  input  logic             dut_done_port,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_status,
  output logic [CNT_W-1:0] res_cycles,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // FSM encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RST    = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;

  localparam logic [1:0] ST_DONE    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  // Hold counter runs 0 .. RESET_HOLD-1 while in RST.
  localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [63:0]      TO_LIM  = 64'(TIMEOUT_CYCLES);

`ifdef HLS_RUN_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic [2:0]        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [1:0]        status_nxt;
  logic [CNT_W-1:0]  cycles_nxt;
  logic              rstn_nxt;
  logic              start_nxt;
  logic              valid_nxt;
  logic              accept;
  logic              timeout_hit;

  // req_ready is itself only high in IDLE, so this is the accept strobe.
  assign accept = req_valid & req_ready;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // Watchdog: compared at 64 bits so a limit wider than the counter simply
  // never fires rather than aliasing to a small value.
  assign timeout_hit = TIMEOUT_EN && (state == WAIT) && (64'(cnt) >= TO_LIM);

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    cnt_nxt    = cnt;
    status_nxt = res_status;
    cycles_nxt = res_cycles;
    rstn_nxt   = 1'b1;
    start_nxt  = 1'b0;
    valid_nxt  = res_valid;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RST;
          hold_nxt  = '0;
          rstn_nxt  = 1'b0;
        end
      end

      RST: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = START;
          start_nxt = 1'b1;
          cnt_nxt   = CNT_ONE;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
          rstn_nxt = 1'b0;
        end
      end

      START: begin
        // done in the start cycle itself reports a one-cycle run
        if (dut_done_port) begin
          state_nxt  = REPORT;
          cycles_nxt = cnt;
          status_nxt = ST_DONE;
          valid_nxt  = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = cnt_inc;
        end
      end

      WAIT: begin
        // done has priority over a watchdog expiry in the same cycle
        if (dut_done_port) begin
          state_nxt  = REPORT;
          cycles_nxt = cnt;
          status_nxt = ST_DONE;
          valid_nxt  = 1'b1;
        end else if (timeout_hit) begin
          state_nxt  = REPORT;
          cycles_nxt = cnt;
          status_nxt = ST_TIMEOUT;
          valid_nxt  = 1'b1;
          // a hung core gets a one-cycle reset as the record goes out
          rstn_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      REPORT: begin
        if (res_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      cnt            <= '0;
      req_ready      <= 1'b0;
      dut_reset_n    <= 1'b0;
      dut_start_port <= 1'b0;
      res_valid      <= 1'b0;
      res_status     <= 2'b00;
      res_cycles     <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_nxt;
      cnt            <= cnt_nxt;
      // registered from the next state so req_ready/busy line up with state
      req_ready      <= (state_nxt == IDLE);
      busy           <= (state_nxt != IDLE);
      dut_reset_n    <= rstn_nxt;
      dut_start_port <= start_nxt;
      res_valid      <= valid_nxt;
      res_status     <= status_nxt;
      res_cycles     <= cycles_nxt;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hls_run_sequencer
//
// Directed bench for hls_run_sequencer. Two instances share clock and reset:
//   u_dut : CNT_W=32, RESET_HOLD=2, TIMEOUT_CYCLES=50
//   u_sat : CNT_W=4 (saturation)
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hls_run_sequencer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- main instance ----------------
  logic        req_valid, req_ready;
  logic        dut_reset_n, dut_start_port, dut_done_port;
  logic        res_valid, res_ready;
  logic [1:0]  res_status;
  logic [31:0] res_cycles;
  logic        busy;
  logic [2:0]  dbg_state;

  hls_run_sequencer #(
    .CNT_W(32), .RESET_HOLD(2), .TIMEOUT_CYCLES(50)
  ) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .dut_reset_n(dut_reset_n), .dut_start_port(dut_start_port),
    .dut_done_port(dut_done_port),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_status(res_status), .res_cycles(res_cycles),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- saturation instance ----------------
  logic       s_req_valid, s_req_ready;
  logic       s_dut_reset_n, s_dut_start_port, s_dut_done_port;
  logic       s_res_valid, s_res_ready;
  logic [1:0] s_res_status;
  logic [3:0] s_res_cycles;
  logic       s_busy;
  logic [2:0] s_dbg_state;

  hls_run_sequencer #(
    .CNT_W(4), .RESET_HOLD(2), .TIMEOUT_CYCLES(50)
  ) u_sat (
    .clock(clock), .reset(reset),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .dut_reset_n(s_dut_reset_n), .dut_start_port(s_dut_start_port),
    .dut_done_port(s_dut_done_port),
    .res_valid(s_res_valid), .res_ready(s_res_ready),
    .res_status(s_res_status), .res_cycles(s_res_cycles),
    .busy(s_busy), .dbg_state(s_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one full run on u_dut ----------------
  // d       : cycles after the start pulse at which done is raised (-1: never)
  // stall   : REPORT cycles with res_ready held low
  // keep_req: keep req_valid high for the whole run
  task automatic run_main(input int d, input int stall, input bit keep_req,
                          input logic [31:0] exp_cyc, input logic [1:0] exp_st,
                          input string tag);
    int last;
    int extra_starts;
    int early_valid;
    int rstn_lows;
    last         = (d >= 0) ? d : int'(exp_cyc) - 1;
    extra_starts = 0;
    early_valid  = 0;
    rstn_lows    = 0;
    res_ready    = (stall == 0);

    chk({tag, "_req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = keep_req;
    chk({tag, "_rstn_low_1"}, dut_reset_n, 0);
    chk({tag, "_start_low_1"}, dut_start_port, 0);
    chk({tag, "_req_ready_run"}, req_ready, 0);
    chk({tag, "_busy_run"}, busy, 1);
    @(negedge clock);
    chk({tag, "_rstn_low_2"}, dut_reset_n, 0);
    chk({tag, "_start_low_2"}, dut_start_port, 0);
    @(negedge clock);
    chk({tag, "_rstn_release"}, dut_reset_n, 1);
    chk({tag, "_start_pulse"}, dut_start_port, 1);

    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        @(negedge clock);
        if (dut_start_port !== 1'b0) extra_starts++;
        if (res_valid !== 1'b0) early_valid++;
        if (dut_reset_n !== 1'b1) rstn_lows++;
      end
      if (k == d) dut_done_port = 1'b1;
    end
    chk({tag, "_single_start"}, extra_starts, 0);
    chk({tag, "_no_early_valid"}, early_valid, 0);
    chk({tag, "_rstn_high_wait"}, rstn_lows, 0);

    @(negedge clock);
    dut_done_port = 1'b0;
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_status"}, res_status, exp_st);
    chk({tag, "_res_cycles"}, res_cycles, exp_cyc);
    chk({tag, "_rstn_report"}, dut_reset_n, (exp_st == 2'b01) ? 1'b0 : 1'b1);
    chk({tag, "_req_ready_report"}, req_ready, 0);

    if (stall > 0) begin
      for (int s = 1; s <= stall; s++) begin
        @(negedge clock);
        chk({tag, "_stall_valid"}, res_valid, 1);
        chk({tag, "_stall_cycles"}, res_cycles, exp_cyc);
        chk({tag, "_stall_status"}, res_status, exp_st);
        chk({tag, "_stall_req_ready"}, req_ready, 0);
      end
      res_ready = 1'b1;
    end

    @(negedge clock);
    chk({tag, "_valid_drop"}, res_valid, 0);
    chk({tag, "_req_ready_back"}, req_ready, 1);
    chk({tag, "_busy_drop"}, busy, 0);
    chk({tag, "_rstn_idle"}, dut_reset_n, 1);
    req_valid = 1'b0;
  endtask

  // ---------------- driver: one run on u_sat ----------------
  task automatic run_sat(input int d, input logic [3:0] exp_cyc, input string tag);
    chk({tag, "_req_ready_idle"}, s_req_ready, 1);
    s_req_valid = 1'b1;
    @(negedge clock);
    s_req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_start_pulse"}, s_dut_start_port, 1);
    repeat (d) @(negedge clock);
    s_dut_done_port = 1'b1;
    @(negedge clock);
    s_dut_done_port = 1'b0;
    chk({tag, "_res_valid"}, s_res_valid, 1);
    chk({tag, "_res_status"}, s_res_status, 0);
    chk({tag, "_res_cycles"}, s_res_cycles, exp_cyc);
    @(negedge clock);
    chk({tag, "_valid_drop"}, s_res_valid, 0);
    chk({tag, "_req_ready_back"}, s_req_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset           = 1'b1;
    req_valid       = 1'b0;
    dut_done_port   = 1'b0;
    res_ready       = 1'b1;
    s_req_valid     = 1'b0;
    s_dut_done_port = 1'b0;
    s_res_ready     = 1'b1;

    // reset values
    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dut_reset_n", dut_reset_n, 0);
    chk("rst_start", dut_start_port, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_status", res_status, 0);
    chk("rst_res_cycles", res_cycles, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_sat_req_ready", s_req_ready, 0);

    // first edge after release
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_dut_reset_n", dut_reset_n, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sat_state", s_dbg_state, 0);

    // done is ignored while idle
    dut_done_port = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_done_no_valid", res_valid, 0);
    chk("idle_done_no_busy", busy, 0);
    dut_done_port = 1'b0;

    // T1: done 9 cycles after start -> 10
    run_main(9, 0, 1'b0, 32'd10, 2'b00, "t1");
    // T2: done in the start cycle -> 1
    run_main(0, 0, 1'b0, 32'd1, 2'b00, "t2");
    // T3: consumer stalls 5 cycles, request held high
    run_main(4, 5, 1'b1, 32'd5, 2'b00, "t3");
    // longer run with short stall
    run_main(20, 2, 1'b0, 32'd21, 2'b00, "t_long");

`ifdef HLS_RUN_TIMEOUT_EN
    // T4: watchdog expiry, then done exactly at the limit
    run_main(-1, 0, 1'b0, 32'd50, 2'b01, "t4_timeout");
    run_main(49, 0, 1'b0, 32'd50, 2'b00, "t4_done_wins");
`else
    // no watchdog: a run beyond 50 cycles completes normally
    run_main(60, 0, 1'b0, 32'd61, 2'b00, "t_no_watchdog");
`endif

    // T5: reset in WAIT at counter 7
    chk("t5_req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("t5_start_pulse", dut_start_port, 1);
    repeat (6) @(negedge clock);
    chk("t5_busy_wait", busy, 1);
    reset = 1'b1;
    #1;
    chk("t5_async_req_ready", req_ready, 0);
    chk("t5_async_rstn", dut_reset_n, 0);
    chk("t5_async_start", dut_start_port, 0);
    chk("t5_async_res_valid", res_valid, 0);
    chk("t5_async_res_status", res_status, 0);
    chk("t5_async_res_cycles", res_cycles, 0);
    chk("t5_async_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t5_after_req_ready", req_ready, 1);
    chk("t5_after_no_valid", res_valid, 0);
    run_main(3, 0, 1'b0, 32'd4, 2'b00, "t5_rerun");

    // T6: 4-bit counter saturates
    run_sat(14, 4'hF, "t6_exact");
    run_sat(30, 4'hF, "t6_sat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
